// File: rtl/mem_bus_arbiter_if.sv
// Device/CPU/memory signal bundle around the memory bus arbiter.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface mem_bus_arbiter_if;
    logic        dev_req;
    logic        dev_rw;
    logic [15:0] dev_addr;
    logic [7:0]  dev_wdata;
    logic        cpu_busy;
    logic [7:0]  mem_rdata;

    logic        fetch_suppress;
    logic        bus_own;
    logic        dev_gnt;
    logic        dev_done;
    logic [7:0]  dev_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_oe;
    logic        mem_we;

    modport master (
        output dev_req, dev_rw, dev_addr, dev_wdata, cpu_busy, mem_rdata,
        input  fetch_suppress, bus_own, dev_gnt, dev_done, dev_rdata,
               mem_addr, mem_wdata, mem_oe, mem_we
    );

    modport slave (
        input  dev_req, dev_rw, dev_addr, dev_wdata, cpu_busy, mem_rdata,
        output fetch_suppress, bus_own, dev_gnt, dev_done, dev_rdata,
               mem_addr, mem_wdata, mem_oe, mem_we
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Hands the main memory bus from the CPU to a DMA-style device for bursts of
// up to HOLD_MAX beats, then forces a CPU cooldown of CPU_MIN cycles.
module mem_bus_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned CPU_MIN  = 4
) (
    input  logic             MAINCLK,
    input  logic             MAINRST,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        CPU_OWN,
        DRAIN,
        ACCESS,
        DONE,
        RELEASE
    } state_e;

    localparam logic [7:0] HOLD_LIM  = 8'(HOLD_MAX);
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);
    localparam logic [7:0] COOL_INIT = 8'(CPU_MIN);

    state_e      state_q, state_d;
    logic [3:0]  wait_q;
    logic [7:0]  beats_q;
    logic [7:0]  cool_q;
    logic [7:0]  cool_dec;
    logic        rw_q;
    logic        fs_q, own_q, gnt_q, done_q, oe_q, we_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        wait_last;
    logic        enter_access;

    assign cool_dec     = (cool_q == 8'd0) ? 8'd0 : cool_q - 8'd1;
    assign wait_last    = (wait_q == WAIT_LAST);
    assign enter_access = (state_d == ACCESS) && (state_q != ACCESS);

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            // Gate on the count left after this cycle, so the CPU keeps exactly
            // CPU_MIN owned cycles between a release and the next drain.
            CPU_OWN: if (bus.dev_req && cool_dec == 8'd0) state_d = DRAIN;
            DRAIN: begin
                if (!bus.dev_req)       state_d = RELEASE;
                else if (!bus.cpu_busy) state_d = ACCESS;
            end
            ACCESS:  if (wait_last) state_d = DONE;
            DONE:    state_d = (bus.dev_req && beats_q < HOLD_LIM) ? ACCESS : RELEASE;
            RELEASE: state_d = CPU_OWN;
            default: state_d = CPU_OWN;
        endcase
    end

    // NOTE: every register here uses <= so all of them see the pre-edge values together.
    always_ff @(posedge MAINCLK) begin
        if (!MAINRST) begin
            state_q <= CPU_OWN;
            wait_q  <= 4'd0;
            beats_q <= 8'd0;
            cool_q  <= 8'd0;
            rw_q    <= 1'b0;
            fs_q    <= 1'b0;
            own_q   <= 1'b0;
            gnt_q   <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;

            // Outputs are decoded from the next state so they line up with state_q.
            fs_q   <= (state_d != CPU_OWN);
            own_q  <= (state_d == ACCESS) || (state_d == DONE);
            gnt_q  <= (state_d == ACCESS) || (state_d == DONE);
            done_q <= (state_d == DONE);

            if (enter_access) begin
                rw_q    <= bus.dev_rw;
                addr_q  <= bus.dev_addr;
                wdata_q <= bus.dev_wdata;
                oe_q    <= !bus.dev_rw;
                we_q    <= bus.dev_rw;
                wait_q  <= 4'd0;
            end else if (state_d == ACCESS) begin
                wait_q <= wait_q + 4'd1;
            end else begin
                oe_q   <= 1'b0;
                we_q   <= 1'b0;
                wait_q <= 4'd0;
                if (state_d != DONE) begin
                    addr_q  <= 16'h0000;
                    wdata_q <= 8'h00;
                end
            end

            if (state_q == ACCESS && wait_last) begin
                beats_q <= beats_q + 8'd1;
                if (!rw_q) rdata_q <= bus.mem_rdata;
            end

            if (state_q == RELEASE) begin
                cool_q  <= COOL_INIT;
                beats_q <= 8'd0;
            end else if (state_q == CPU_OWN) begin
                cool_q <= cool_dec;
            end
        end
    end

    assign bus.fetch_suppress = fs_q;
    assign bus.bus_own        = own_q;
    assign bus.dev_gnt        = gnt_q;
    assign bus.dev_done       = done_q;
    assign bus.dev_rdata      = rdata_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_oe         = oe_q;
    assign bus.mem_we         = we_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter at default parameters (HOLD_MAX=8, MEM_WAIT=1, CPU_MIN=4).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   n_done, n_free, n_both;
    logic [5:0] outs;

    // {fetch_suppress, bus_own, dev_gnt, dev_done, mem_oe, mem_we}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_DRAIN = 6'b100000;
    localparam logic [5:0] O_RD    = 6'b111010;
    localparam logic [5:0] O_WR    = 6'b111001;
    localparam logic [5:0] O_DONE  = 6'b111100;
    localparam logic [5:0] O_REL   = 6'b100000;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter dut (
        .MAINCLK (clk),
        .MAINRST (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign outs = {bus.fetch_suppress, bus.bus_own, bus.dev_gnt,
                   bus.dev_done, bus.mem_oe, bus.mem_we};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.dev_req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.dev_req   = 1'b0;
        bus.dev_rw    = 1'b0;
        bus.dev_addr  = 16'h0000;
        bus.dev_wdata = 8'h00;
        bus.cpu_busy  = 1'b0;
        bus.mem_rdata = 8'h00;
        step();
        step();
        check("reset_outs", 16'(outs), 16'(O_IDLE));
        check("reset_rdata", 16'(bus.dev_rdata), 16'h0000);
        check("reset_addr", bus.mem_addr, 16'h0000);

        // Single read, requested on the first edge after reset release
        rst_n         = 1'b1;
        bus.dev_req   = 1'b1;
        bus.dev_rw    = 1'b0;
        bus.dev_addr  = 16'h8010;
        bus.mem_rdata = 8'h5A;
        step(); check("rd_c1_drain", 16'(outs), 16'(O_DRAIN));
        step(); check("rd_c2_access", 16'(outs), 16'(O_RD));
        check("rd_c2_addr", bus.mem_addr, 16'h8010);
        bus.dev_addr = 16'h1234;
        bus.dev_rw   = 1'b1;
        step(); check("rd_c3_access", 16'(outs), 16'(O_RD));
        check("rd_c3_addr_latched", bus.mem_addr, 16'h8010);
        step(); check("rd_c4_done", 16'(outs), 16'(O_DONE));
        check("rd_c4_rdata", 16'(bus.dev_rdata), 16'h005A);
        bus.dev_req = 1'b0;
        bus.dev_rw  = 1'b0;
        step(); check("rd_c5_release", 16'(outs), 16'(O_REL));
        step(); check("rd_c6_idle", 16'(outs), 16'(O_IDLE));
        check("rd_c6_rdata_held", 16'(bus.dev_rdata), 16'h005A);
        idle(5);

        // Single write; read data must not move
        bus.dev_req   = 1'b1;
        bus.dev_rw    = 1'b1;
        bus.dev_addr  = 16'h9000;
        bus.dev_wdata = 8'hC3;
        bus.mem_rdata = 8'hEE;
        step(); check("wr_c1_drain", 16'(outs), 16'(O_DRAIN));
        step(); check("wr_c2_access", 16'(outs), 16'(O_WR));
        check("wr_c2_wdata", 16'(bus.mem_wdata), 16'h00C3);
        check("wr_c2_addr", bus.mem_addr, 16'h9000);
        step(); check("wr_c3_access", 16'(outs), 16'(O_WR));
        step(); check("wr_c4_done", 16'(outs), 16'(O_DONE));
        check("wr_c4_rdata_kept", 16'(bus.dev_rdata), 16'h005A);
        bus.dev_req = 1'b0;
        step(); check("wr_c5_release", 16'(outs), 16'(O_REL));
        step(); check("wr_c6_idle", 16'(outs), 16'(O_IDLE));
        idle(5);

        // CPU still busy: drain holds without taking the bus
        bus.dev_req   = 1'b1;
        bus.dev_rw    = 1'b0;
        bus.dev_addr  = 16'h0042;
        bus.mem_rdata = 8'h77;
        bus.cpu_busy  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("drain_busy_c%0d", i), 16'(outs), 16'(O_DRAIN));
        end
        bus.cpu_busy = 1'b0;
        step(); check("drain_access_c5", 16'(outs), 16'(O_RD));
        step(); check("drain_access_c6", 16'(outs), 16'(O_RD));
        step(); check("drain_done_c7", 16'(outs), 16'(O_DONE));
        check("drain_rdata", 16'(bus.dev_rdata), 16'h0077);
        bus.dev_req = 1'b0;
        step(); check("drain_release", 16'(outs), 16'(O_REL));
        idle(5);

        // Request withdrawn while draining
        bus.dev_req = 1'b1;
        step(); check("wd_drain", 16'(outs), 16'(O_DRAIN));
        bus.dev_req = 1'b0;
        step(); check("wd_release", 16'(outs), 16'(O_REL));
        step(); check("wd_idle", 16'(outs), 16'(O_IDLE));
        idle(5);

        // Burst cap: 8 beats, release, 4 CPU cycles, then drain again
        bus.dev_req   = 1'b1;
        bus.dev_rw    = 1'b0;
        bus.dev_addr  = 16'h4000;
        bus.mem_rdata = 8'h3C;
        n_done = 0;
        n_free = 0;
        n_both = 0;
        for (int c = 1; c <= 31; c++) begin
            step();
            if (bus.dev_done) n_done++;
            if (!bus.fetch_suppress) n_free++;
            if (bus.mem_oe && bus.mem_we) n_both++;
            if (c == 25) check("burst_last_done", 16'(outs), 16'(O_DONE));
            if (c == 26) check("burst_release", 16'(outs), 16'(O_REL));
            if (c == 31) check("burst_redrain", 16'(outs), 16'(O_DRAIN));
        end
        check("burst_done_count", 16'(n_done), 16'd8);
        check("burst_cpu_cycles", 16'(n_free), 16'd4);
        check("burst_oe_we_both", 16'(n_both), 16'd0);
        check("burst_rdata", 16'(bus.dev_rdata), 16'h003C);
        bus.dev_req = 1'b0;
        step(); check("burst_final_release", 16'(outs), 16'(O_REL));
        idle(6);

        // Reset in the first cycle of a write access
        bus.dev_req   = 1'b1;
        bus.dev_rw    = 1'b1;
        bus.dev_addr  = 16'hA000;
        bus.dev_wdata = 8'h55;
        step(); check("rst_drain", 16'(outs), 16'(O_DRAIN));
        step(); check("rst_access", 16'(outs), 16'(O_WR));
        rst_n = 1'b0;
        step(); check("rst_mid_outs", 16'(outs), 16'(O_IDLE));
        check("rst_mid_rdata", 16'(bus.dev_rdata), 16'h0000);
        check("rst_mid_addr", bus.mem_addr, 16'h0000);
        rst_n = 1'b1;
        step(); check("post_rst_drain", 16'(outs), 16'(O_DRAIN));
        bus.dev_req = 1'b0;
        step(); check("post_rst_release", 16'(outs), 16'(O_REL));
        step(); check("post_rst_idle", 16'(outs), 16'(O_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8: max device beats per bus tenure before forced release (1..255).
REQ-002 Parameter MEM_WAIT, default 1: extra cycles per memory access; an access lasts MEM_WAIT+1 cycles (0..15).
REQ-003 Parameter CPU_MIN, default 4: minimum CPU-owned cycles after a release before dev_req is honoured again (0..255).
REQ-004 MAINCLK  in  1  sole clock; all state changes on rising edge.
REQ-005 MAINRST  in  1  synchronous reset, active low.
REQ-006 dev_req  in  1  device requests the memory bus; one beat per dev_done.
REQ-007 dev_rw  in  1  1 = write, 0 = read.
REQ-008 dev_addr  in  16  beat address.
REQ-009 dev_wdata  in  8  write data.
REQ-010 cpu_busy  in  1  pipeline has a memory cycle in flight and cannot yield yet.
REQ-011 mem_rdata  in  8  memory read data.
REQ-012 fetch_suppress  out  1  stalls pipeline fetch and memory control.
REQ-013 bus_own  out  1  device owns address/memory data buses; CPU address drivers tristate.
REQ-014 dev_gnt  out  1  device tenure active.
REQ-015 dev_done  out  1  one-cycle pulse: beat complete.
REQ-016 dev_rdata  out  8  read data, valid with dev_done, held until next dev_done.
REQ-017 mem_addr  out  16; mem_wdata  out  8; mem_oe  out  1; mem_we  out  1: memory drive toward MainMemory.

Function
REQ-018 FSM states CPU_OWN, DRAIN, ACCESS, DONE, RELEASE; all outputs registered/decoded from state only (Moore).
REQ-019 CPU_OWN: all outputs 0; dev_req=1 and cooldown=0 -> DRAIN.
REQ-020 DRAIN: fetch_suppress=1; dev_req=0 -> RELEASE; dev_req=1 and cpu_busy=0 -> ACCESS; else stay.
REQ-021 Entering ACCESS latches dev_addr/dev_wdata/dev_rw into mem_addr/mem_wdata/rw; wait counter cleared.
REQ-022 ACCESS: fetch_suppress=bus_own=dev_gnt=1; mem_oe=!rw, mem_we=rw; stays MEM_WAIT+1 cycles; on last cycle edge captures mem_rdata into dev_rdata (reads only), beat counter +1 -> DONE.
REQ-023 DONE: dev_done=1, dev_gnt=bus_own=fetch_suppress=1, mem_oe=mem_we=0; device presents next beat fields or drops dev_req within this cycle (combinational on dev_done allowed).
REQ-024 DONE exit: dev_req=1 and beats<HOLD_MAX -> ACCESS (re-latch per REQ-021); otherwise -> RELEASE.
REQ-025 RELEASE: one turnaround cycle, fetch_suppress=1, bus_own=dev_gnt=0, mem_* =0; -> CPU_OWN, cooldown loaded with CPU_MIN, beat counter cleared.
REQ-026 Cooldown decrements each CPU_OWN cycle, saturates at 0; dev_req ignored while nonzero.
REQ-027 mem_we never 1 outside ACCESS; mem_oe and mem_we never both 1.
REQ-028 dev_rw/dev_addr changes during ACCESS have no effect (latched values used).
REQ-029 Minimum request-to-first-dev_done latency: 3+MEM_WAIT cycles.

Reset
REQ-030 MAINRST=0 at an edge, in any state including mid-ACCESS write: state CPU_OWN, all outputs 0, dev_rdata=0x00, beat/wait/cooldown counters 0; in-flight beat abandoned, no dev_done.
REQ-031 First cycle after reset release honours dev_req (cooldown=0).

Verification
REQ-032 Single read: MEM_WAIT=1, cpu_busy=0, dev_req=1 rw=0 addr=0x8010 sampled at edge 0, mem_rdata=0x5A, dev_req dropped in DONE -> fetch_suppress=1 cycles 1-5; mem_oe=1 mem_addr=0x8010 cycles 2-3; dev_done=1, dev_rdata=0x5A cycle 4; RELEASE cycle 5; all outputs 0 cycle 6.
REQ-033 Drain: cpu_busy=1 for 3 cycles after DRAIN entry -> no ACCESS, bus_own=0 until cpu_busy falls; ACCESS the cycle after.
REQ-034 Burst cap: dev_req held high, HOLD_MAX=8, CPU_MIN=4 -> exactly 8 dev_done pulses, RELEASE, 4 cycles with fetch_suppress=0, then DRAIN.
REQ-035 Write: rw=1 addr=0x9000 wdata=0xC3 -> mem_we=1, mem_wdata=0xC3, mem_oe=0 for MEM_WAIT+1 cycles; dev_rdata unchanged.
REQ-036 Reset mid-write: MAINRST=0 during ACCESS cycle 1 -> next cycle mem_we=0, bus_own=0, fetch_suppress=0, no dev_done.
REQ-037 Withdraw: dev_req dropped in DRAIN -> RELEASE, no mem_oe/mem_we activity, no dev_done.
